// File: rtl/bit_rev_buffer.sv
// Ping-pong frame buffer that accepts samples in natural order and emits them in bit-reversed order.
// Optional frame-last marker output is enabled by defining FRAME_LAST_EN.
module bit_rev_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FFT_SIZE   = 64
) (
    input  logic                  clkIn,
    input  logic                  rstNIn,
    input  logic                  inValidIn,
    output logic                  inConsentOut,
    input  logic [DATA_WIDTH-1:0] inDataIn,
    output logic                  outValidOut,
    input  logic                  outConsentIn,
    output logic [DATA_WIDTH-1:0] outDataOut
`ifdef FRAME_LAST_EN
    ,
    output logic                  outLastOut
`endif
);

    localparam int              LOG2     = $clog2(FFT_SIZE);
    localparam logic [LOG2-1:0] LAST_IDX = '1;

    logic [DATA_WIDTH-1:0] bankMem [2*FFT_SIZE];

    logic            wrBank;
    logic            rdBank;
    logic            readyR;
    logic [LOG2-1:0] wrIdx;
    logic [LOG2-1:0] rdIdx;
    logic [LOG2-1:0] rdIdxRev;
    logic [1:0]      full;
    logic [1:0]      fullNext;
    logic            inXfer;
    logic            outXfer;

    // Consent depends only on flops so upstream never sees a combinational loop.
    assign inConsentOut = readyR & ~full[wrBank];
    assign outValidOut  = full[rdBank];
    assign inXfer       = inValidIn & inConsentOut;
    assign outXfer      = outValidOut & outConsentIn;

    always_comb begin
        rdIdxRev = '0;
        for (int i = 0; i < LOG2; i++) begin
            rdIdxRev[i] = rdIdx[LOG2-1-i];
        end
    end

    assign outDataOut = bankMem[{rdBank, rdIdxRev}];

`ifdef FRAME_LAST_EN
    assign outLastOut = outValidOut & (rdIdx == LAST_IDX);
`endif

    // Read and write banks always differ when both transfers complete a frame together.
    always_comb begin
        fullNext = full;
        if (inXfer && (wrIdx == LAST_IDX)) begin
            fullNext[wrBank] = 1'b1;
        end
        if (outXfer && (rdIdx == LAST_IDX)) begin
            fullNext[rdBank] = 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (inXfer) begin
            bankMem[{wrBank, wrIdx}] <= inDataIn;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wrBank <= 1'b0;
            rdBank <= 1'b0;
            wrIdx  <= '0;
            rdIdx  <= '0;
            full   <= '0;
            readyR <= 1'b0;
        end else begin
            readyR <= 1'b1;
            full   <= fullNext;
            if (inXfer) begin
                wrIdx <= wrIdx + 1'b1;
                if (wrIdx == LAST_IDX) begin
                    wrBank <= ~wrBank;
                end
            end
            if (outXfer) begin
                rdIdx <= rdIdx + 1'b1;
                if (rdIdx == LAST_IDX) begin
                    rdBank <= ~rdBank;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_rev_buffer.sv
// Self-checking bench for bit_rev_buffer (FFT_SIZE=8): table-driven frame vectors plus
// randomized traffic checked against a frame-level bit-reverse model.
module tb_bit_rev_buffer;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int LG = 3;

    logic          clkIn = 1'b0;
    logic          rstNIn = 1'b0;
    logic          inValidIn = 1'b0;
    logic          outConsentIn = 1'b0;
    logic [DW-1:0] inDataIn = '0;
    logic          inConsentOut;
    logic          outValidOut;
    logic [DW-1:0] outDataOut;
`ifdef FRAME_LAST_EN
    logic          outLastOut;
`endif

    always #5 clkIn = ~clkIn;

    bit_rev_buffer #(.DATA_WIDTH(DW), .FFT_SIZE(N)) dut (
        .clkIn        (clkIn),
        .rstNIn       (rstNIn),
        .inValidIn    (inValidIn),
        .inConsentOut (inConsentOut),
        .inDataIn     (inDataIn),
        .outValidOut  (outValidOut),
        .outConsentIn (outConsentIn),
        .outDataOut   (outDataOut)
`ifdef FRAME_LAST_EN
        ,
        .outLastOut   (outLastOut)
`endif
    );

    typedef struct {
        bit          vin;
        logic [DW-1:0] din;
        bit          cons;
        bit          expValid;
        bit          expCons;
        logic [DW-1:0] expData;
        bit          expLast;
    } vec_t;

    vec_t          tbl [17];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] accQ [$];
    int            nIn, nOut;
    int            dutAccepts, dutOuts;

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LG; i++) begin
            r = r * 2 + (k % 2);
            k = k / 2;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge: check outputs against the model, then drive the next inputs.
    task automatic step(input bit vin, input logic [DW-1:0] din, input bit cons);
        int pending = nIn / N - nOut / N;
        bit expValid = (pending > 0);
        bit expCons  = (pending < 2);
        chk("in_consent", 32'(inConsentOut), 32'(expCons));
        chk("out_valid", 32'(outValidOut), 32'(expValid));
        if (expValid) begin
            chk("out_data", 32'(outDataOut), 32'(accQ[(nOut / N) * N + brev(nOut % N)]));
        end
`ifdef FRAME_LAST_EN
        chk("out_last", 32'(outLastOut), 32'(expValid && (nOut % N == N - 1)));
`endif
        inValidIn    = vin;
        inDataIn     = din;
        outConsentIn = cons;
        if (inValidIn && inConsentOut) dutAccepts++;
        if (outValidOut && outConsentIn) dutOuts++;
        if (vin && expCons) begin
            accQ.push_back(din);
            nIn++;
        end
        if (cons && expValid) nOut++;
        @(negedge clkIn);
    endtask

    task automatic doReset();
        rstNIn       = 1'b0;
        inValidIn    = 1'b0;
        outConsentIn = 1'b0;
        inDataIn     = '0;
        #1;
        chk("rst_consent", 32'(inConsentOut), 32'd0);
        chk("rst_valid", 32'(outValidOut), 32'd0);
`ifdef FRAME_LAST_EN
        chk("rst_last", 32'(outLastOut), 32'd0);
`endif
        @(negedge clkIn);
        @(negedge clkIn);
        accQ.delete();
        nIn        = 0;
        nOut       = 0;
        dutAccepts = 0;
        dutOuts    = 0;
        rstNIn     = 1'b1;
        #1;
        chk("pre_ready_consent", 32'(inConsentOut), 32'd0);
        @(negedge clkIn);
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < 17; i++) begin
            chk({tag, "_consent"}, 32'(inConsentOut), 32'(tbl[i].expCons));
            chk({tag, "_valid"}, 32'(outValidOut), 32'(tbl[i].expValid));
            if (tbl[i].expValid) chk({tag, "_data"}, 32'(outDataOut), 32'(tbl[i].expData));
`ifdef FRAME_LAST_EN
            chk({tag, "_last"}, 32'(outLastOut), 32'(tbl[i].expLast));
`endif
            inValidIn    = tbl[i].vin;
            inDataIn     = tbl[i].din;
            outConsentIn = tbl[i].cons;
            @(negedge clkIn);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int revOrder [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int firstV, lastV, validCount, cyc;

        for (int i = 0; i < 17; i++) begin
            tbl[i].vin      = (i < 8);
            tbl[i].din      = (i < 8) ? DW'(i) : '0;
            tbl[i].cons     = 1'b1;
            tbl[i].expCons  = 1'b1;
            tbl[i].expValid = (i >= 8 && i < 16);
            tbl[i].expData  = (i >= 8 && i < 16) ? DW'(revOrder[i-8]) : '0;
            tbl[i].expLast  = (i == 15);
        end

        @(negedge clkIn);

        // Single frame, fixed expected order.
        doReset();
        runTable("frame0");

        // Downstream stalled: two frames fill, third blocked, then drain.
        doReset();
        for (int k = 0; k < 20; k++) step(1'b1, DW'(nIn), 1'b0);
        chk("stall_accepted", 32'(dutAccepts), 32'd16);
        for (int k = 0; k < 18; k++) step(1'b0, '0, 1'b1);
        chk("stall_drained", 32'(dutOuts), 32'd16);

        // Four back-to-back frames at full rate.
        doReset();
        firstV = -1;
        lastV = -1;
        validCount = 0;
        for (int c = 0; c < 44; c++) begin
            if (outValidOut) begin
                if (firstV < 0) firstV = c;
                lastV = c;
                validCount++;
            end
            step(nIn < 32, DW'(nIn), 1'b1);
        end
        chk("stream_outputs", 32'(dutOuts), 32'd32);
        chk("stream_valid_cycles", 32'(validCount), 32'd32);
        chk("stream_first_valid", 32'(firstV), 32'd8);
        chk("stream_span", 32'(lastV - firstV + 1), 32'd32);

        // Reset asserted mid-frame with a full frame pending.
        doReset();
        for (int k = 0; k < 13; k++) step(1'b1, DW'(nIn), 1'b0);
        chk("prereset_valid", 32'(outValidOut), 32'd1);
        rstNIn = 1'b0;
        #1;
        chk("midreset_valid", 32'(outValidOut), 32'd0);
        chk("midreset_consent", 32'(inConsentOut), 32'd0);
        @(negedge clkIn);
        doReset();
        runTable("after_reset");

        // Randomized handshakes on both sides.
        doReset();
        cyc = 0;
        while (nOut < 800 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            cyc++;
        end
        chk("random_outputs", 32'(dutOuts), 32'd800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_rev_buffer.md
BIT_REV_BUFFER -- requirements
Module: bit_rev_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the sample width in bits.
REQ-002 SHALL have parameter FFT_SIZE, default 64, the frame length in samples; power of two, at least 2; LOG2 = $clog2(FFT_SIZE).
REQ-003 SHALL have port clkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstNIn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port inValidIn, input, 1 bit: an upstream sample is present (connects to the upstream FIFO rdValidOut).
REQ-006 SHALL have port inConsentOut, output, 1 bit: the block accepts a sample this cycle (connects to the upstream FIFO rdConsentIn).
REQ-007 SHALL have port inDataIn, input, DATA_WIDTH bits: the upstream sample, in natural order.
REQ-008 SHALL have port outValidOut, output, 1 bit: an output sample is present.
REQ-009 SHALL have port outConsentIn, input, 1 bit: downstream accepts the output sample.
REQ-010 SHALL have port outDataOut, output, DATA_WIDTH bits: the output sample, in bit-reversed order.
REQ-011 SHALL have port outLastOut, output, 1 bit, present only under FRAME_LAST_EN: marks the final sample of a frame.

Function
REQ-012 SHALL buffer frames in two banks (ping-pong), each FFT_SIZE x DATA_WIDTH; each bank has a full flag.
REQ-013 SHALL treat an input transfer as inValidIn & inConsentOut, and an output transfer as outValidOut & outConsentIn.
REQ-014 SHALL, on an input transfer, write inDataIn to bank wrBank at index wrIdx, then increment wrIdx (LOG2 bits, wrapping).
REQ-015 SHALL, when wrIdx = FFT_SIZE-1 at an input transfer, set full[wrBank], toggle wrBank and wrap wrIdx to 0.
REQ-016 SHALL drive inConsentOut = readyR & ~full[wrBank], derived from flops only; no combinational path from any input.
REQ-017 SHALL drive outValidOut = full[rdBank].
REQ-018 SHALL drive outDataOut = bank[rdBank][bitrev(rdIdx)]; bitrev reverses the LOG2 bits of rdIdx.
REQ-019 SHALL hold outDataOut and outValidOut stable while outValidOut=1 and outConsentIn=0.
REQ-020 SHALL, on an output transfer, increment rdIdx; when rdIdx = FFT_SIZE-1 it SHALL clear full[rdBank], toggle rdBank and wrap rdIdx to 0.
REQ-021 SHALL make the first sample of a frame valid on the cycle after the clock edge that accepts that frame's last input sample; input-to-output latency is 1 cycle past frame completion.
REQ-022 SHALL allow an input transfer and an output transfer in the same cycle; they necessarily target different banks.
REQ-023 SHALL, when both banks are full, hold inConsentOut=0 and ignore inValidIn.
REQ-024 SHALL, when the last sample of a bank drains while the write side waits on that bank, raise inConsentOut on the next cycle; there is no same-cycle bypass.
REQ-025 SHALL, for sustained valid/consent on both sides, reach throughput of 1 sample per cycle with no bubbles between frames.

Reset
REQ-026 SHALL, while rstNIn=0, force wrBank=0, rdBank=0, wrIdx=0, rdIdx=0, both full flags 0 and readyR=0, giving inConsentOut=0, outValidOut=0 and outLastOut=0.
REQ-027 SHALL set readyR=1 on the first rising clkIn edge after rstNIn deasserts; the bank contents SHALL NOT be reset.
REQ-028 SHALL, on reset asserted mid-frame, discard all partial and full frames; the first frame after reset starts at index 0 of bank 0.

Configuration
REQ-029 SHALL, when macro FRAME_LAST_EN is defined, provide outLastOut = outValidOut & (rdIdx = FFT_SIZE-1).
REQ-030 SHALL, when FRAME_LAST_EN is not defined, omit port outLastOut and its logic; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover this scenario: FFT_SIZE=8, after reset feed samples 0..7 with outConsentIn=1 -> outputs 0,4,2,6,1,5,3,7; first outValidOut on the cycle after sample 7 is accepted.
REQ-032 SHALL cover this scenario: FFT_SIZE=8, outConsentIn=0, feed 20 samples continuously -> exactly 16 accepted; inConsentOut=0 from cycle 17 on; releasing consent drains 0,4,2,6,... then 8,12,10,14,...
REQ-033 SHALL cover this scenario: FFT_SIZE=8, continuous valid and consent for 4 frames -> 32 outputs, no bubble after the first frame latency, each frame bit-reversed.
REQ-034 SHALL cover this scenario: random inValidIn and outConsentIn at 50% over 100 frames -> output equals a bit-reverse model; outDataOut stable whenever stalled.
REQ-035 SHALL cover this scenario: assert rstNIn=0 after 5 samples of a frame -> outValidOut=0 and inConsentOut=0 immediately; after release, a fresh 0..7 frame outputs 0,4,2,6,1,5,3,7.
REQ-036 SHALL cover this scenario: with FRAME_LAST_EN, the FFT_SIZE=8 frame -> outLastOut=1 only on the 8th output (value 7).
